// File: rtl/booth_mult_ctrl_if.sv
// booth_mult_ctrl_if: handshake, recoding and datapath-control signals between the
// radix-4 Booth sequencer (slave) and its requester/datapath (master).
// The abort signal exists only when BOOTH_ABORT_EN is defined.
interface booth_mult_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH / 2)
);
    logic          start;
    logic          result_ack;
    logic [1:0]    lower2;
`ifdef BOOTH_ABORT_EN
    logic          abort;
`endif
    logic          prod_ena;
    logic          prod_init;
    logic          pp_zero;
    logic          pp_neg;
    logic          pp_dbl;
    logic          busy;
    logic          result_valid;
    logic [CW-1:0] iter;

    modport master (
`ifdef BOOTH_ABORT_EN
        output abort,
`endif
        output start, result_ack, lower2,
        input  prod_ena, prod_init, pp_zero, pp_neg, pp_dbl, busy, result_valid, iter
    );

    modport slave (
`ifdef BOOTH_ABORT_EN
        input  abort,
`endif
        input  start, result_ack, lower2,
        output prod_ena, prod_init, pp_zero, pp_neg, pp_dbl, busy, result_valid, iter
    );
endinterface

// File: rtl/booth_mult_ctrl.sv
// booth_mult_ctrl: sequencer for a radix-4 Booth multiplier. Loads the external
// product register, runs WIDTH/2 shift-by-2 iterations recoding {lower2, prev}
// into partial-product selects, then holds the result until acknowledged.
// Optional feature macro: BOOTH_ABORT_EN (adds abort of an operation in progress).
module booth_mult_ctrl #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH / 2)
) (
    input logic             clk,
    input logic             clr,
    booth_mult_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH / 2 - 1);

    logic [1:0]    state_q;
    logic          prev_q;
    logic [CW-1:0] iter_q;
    logic          in_run;
    logic          abort_hit;

    assign in_run = (state_q == S_LOAD) || (state_q == S_ITER);

`ifdef BOOTH_ABORT_EN
    assign abort_hit = bus.abort && in_run;
`else
    assign abort_hit = 1'b0;
`endif

    // State, saved recoding bit and iteration counter; clr beats abort beats completion.
    always_ff @(posedge clk) begin
        if (clr || abort_hit) begin
            state_q <= S_IDLE;
            prev_q  <= 1'b0;
            iter_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) state_q <= S_LOAD;
                end
                S_LOAD: begin
                    prev_q  <= 1'b0;
                    iter_q  <= '0;
                    state_q <= S_ITER;
                end
                S_ITER: begin
                    prev_q <= bus.lower2[1];
                    if (iter_q == LAST_ITER) begin
                        iter_q  <= '0;
                        state_q <= S_DONE;
                    end else begin
                        iter_q <= iter_q + CW'(1);
                    end
                end
                default: begin
                    if (bus.result_ack) state_q <= bus.start ? S_LOAD : S_IDLE;
                end
            endcase
        end
    end

    // Radix-4 recoding of {lower2[1], lower2[0], prev}; only active while iterating.
    always_comb begin
        bus.pp_zero = 1'b0;
        bus.pp_neg  = 1'b0;
        bus.pp_dbl  = 1'b0;
        if (state_q == S_ITER) begin
            case ({bus.lower2, prev_q})
                3'b000, 3'b111: bus.pp_zero = 1'b1;
                3'b011:         bus.pp_dbl  = 1'b1;
                3'b100: begin
                    bus.pp_neg = 1'b1;
                    bus.pp_dbl = 1'b1;
                end
                3'b101, 3'b110: bus.pp_neg  = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.busy         = in_run;
    assign bus.prod_ena     = in_run;
    assign bus.prod_init    = (state_q == S_LOAD);
    assign bus.result_valid = (state_q == S_DONE);
    assign bus.iter         = iter_q;
endmodule

// File: tb/tb_booth_mult_ctrl.sv
// tb_booth_mult_ctrl: random and directed multiplies through a behavioural
// product-register datapath; a scoreboard compares each finished product
// against the signed product of the operands and checks latency/busy length.
module tb_booth_mult_ctrl;
    localparam int WIDTH = 32;
    localparam int HALF  = WIDTH / 2;

    typedef struct {
        longint prod;
        int     t0;
    } sb_entry_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    sb_entry_t sb_q[$];

    logic [31:0]        mcand  = '0;
    logic [31:0]        mplier = '0;
    logic signed [33:0] dp_hi  = '0;
    logic [31:0]        dp_lo  = '0;

    booth_mult_ctrl_if #(.WIDTH(WIDTH)) bus ();

    booth_mult_ctrl #(.WIDTH(WIDTH)) u_dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.lower2 = dp_lo[1:0];

    // External datapath: upper += +-M/2M, then arithmetic shift of the whole register by 2.
    function automatic logic [65:0] dp_step(input logic signed [33:0] hi, input logic [31:0] lo,
                                            input logic [31:0] m, input logic z, input logic n,
                                            input logic d);
        logic signed [33:0] m_ext;
        logic signed [33:0] addend;
        logic signed [65:0] full;
        m_ext  = {{2{m[31]}}, m};
        addend = z ? 34'sd0 : (d ? (m_ext <<< 1) : m_ext);
        if (n) addend = -addend;
        full = {hi + addend, lo};
        return full >>> 2;
    endfunction

    always @(posedge clk) begin
        if (bus.prod_ena) begin
            if (bus.prod_init) begin
                dp_hi <= '0;
                dp_lo <= mplier;
            end else begin
                logic [65:0] r;
                r = dp_step(dp_hi, dp_lo, mcand, bus.pp_zero, bus.pp_neg, bus.pp_dbl);
                dp_hi <= r[65:32];
                dp_lo <= r[31:0];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: invariants every cycle; scoreboard pop on each new result.
    int   busy_cnt = 0;
    int   ena_cnt  = 0;
    logic rv_d     = 1'b0;
    always @(negedge clk) begin
        if (!clr) begin
            chk("pp_exclusive", {63'd0, bus.pp_zero && (bus.pp_neg || bus.pp_dbl)}, 64'd0);
            chk("pp_outside_iter", {63'd0, (!bus.busy || bus.prod_init) &&
                (bus.pp_zero || bus.pp_neg || bus.pp_dbl)}, 64'd0);
        end
        if (bus.busy)     busy_cnt++;
        if (bus.prod_ena) ena_cnt++;
        if (bus.result_valid && !rv_d) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 64'd1, 64'd0);
            end else begin
                sb_entry_t e;
                e = sb_q.pop_front();
                chk("product", {dp_hi[31:0], dp_lo}, e.prod);
                chk("latency", 64'(cyc - e.t0), 64'(HALF + 1));
                chk("busy_len", 64'(busy_cnt), 64'(HALF + 1));
                chk("ena_len", 64'(ena_cnt), 64'(HALF + 1));
            end
            busy_cnt = 0;
            ena_cnt  = 0;
        end
        if (!bus.busy && !bus.result_valid) begin
            busy_cnt = 0;
            ena_cnt  = 0;
        end
        rv_d = bus.result_valid;
    end

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [10:0] outs();
        return {bus.busy, bus.prod_ena, bus.prod_init, bus.result_valid,
                bus.pp_zero, bus.pp_neg, bus.pp_dbl, bus.iter};
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        sb_entry_t e;
        mcand     = a;
        mplier    = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        e.prod = longint'($signed(a)) * longint'($signed(b));
        e.t0   = cyc;
        sb_q.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.result_valid && n < 4 * HALF) begin
            bus.start = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            n++;
        end
        bus.start = 1'b0;
        chk("done_reached", {63'd0, bus.result_valid}, 64'd1);
    endtask

    task automatic wait_iter(input int target);
        int n = 0;
        while (!(bus.busy && !bus.prod_init && int'(bus.iter) == target) && n < 4 * HALF) begin
            @(posedge clk); #1;
            n++;
        end
        chk("iter_reached", 64'(bus.iter), 64'(target));
    endtask

    task automatic ack_op(input int hold);
        for (int i = 0; i < hold; i++) begin
            bus.start = i[0];
            @(posedge clk); #1;
            chk("hold_done", {62'd0, bus.result_valid, bus.busy}, 64'b10);
        end
        bus.start      = 1'b0;
        bus.result_ack = 1'b1;
        @(posedge clk); #1;
        bus.result_ack = 1'b0;
        chk("ack_to_idle", 64'(outs()), 64'd0);
    endtask

    task automatic ack_b2b(input logic [31:0] a, input logic [31:0] b);
        bus.result_ack = 1'b1;
        issue(a, b);
        bus.result_ack = 1'b0;
        chk("b2b_load", {61'd0, bus.prod_init, bus.busy, bus.result_valid}, 64'b110);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start      = 1'b0;
        bus.result_ack = 1'b0;
`ifdef BOOTH_ABORT_EN
        bus.abort      = 1'b0;
`endif
        clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'(outs()), 64'd0);
        clr = 1'b0;

        // Recoding of multiplier 3 with M=7: -M, +M, then zeros; product 21.
        issue(32'd7, 32'd3);
        @(posedge clk); #1;
        chk("dec_iter0", {61'd0, bus.pp_zero, bus.pp_neg, bus.pp_dbl}, 64'b010);
        @(posedge clk); #1;
        chk("dec_iter1", {61'd0, bus.pp_zero, bus.pp_neg, bus.pp_dbl}, 64'b000);
        @(posedge clk); #1;
        chk("dec_iter2", {61'd0, bus.pp_zero, bus.pp_neg, bus.pp_dbl}, 64'b100);
        wait_done();
        ack_op(0);

        // Signed multiplicand, then a held result with start pulses ignored.
        issue(32'hFFFF_FFFD, 32'd7);
        wait_done();
        ack_op(5);

        // Back-to-back start with acknowledge.
        issue(32'd12345, 32'hFFFF_0001);
        wait_done();
        ack_b2b(32'h8000_0000, 32'h8000_0000);
        wait_done();
        ack_op(1);

        // Reset mid-run, with start held to confirm clr wins.
        issue(32'd99, 32'd77);
        wait_iter(7);
        clr       = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        clr       = 1'b0;
        bus.start = 1'b0;
        sb_q.delete();
        chk("clr_midrun", 64'(outs()), 64'd0);
        issue(32'hFFFF_FFFF, 32'h7FFF_FFFF);
        wait_done();
        ack_op(0);

`ifdef BOOTH_ABORT_EN
        issue(32'd5, 32'd6);
        wait_iter(5);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        sb_q.delete();
        chk("abort_idle", 64'(outs()), 64'd0);
        repeat (HALF + 4) @(posedge clk);
        #1;
        chk("abort_no_result", {63'd0, bus.result_valid}, 64'd0);

        issue(32'd5, 32'd6);
        wait_iter(HALF - 1);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        sb_q.delete();
        chk("abort_last_iter", 64'(outs()), 64'd0);

        issue(32'd5, 32'd6);
        wait_iter(3);
        bus.abort = 1'b1;
        clr       = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        clr       = 1'b0;
        sb_q.delete();
        chk("clr_with_abort", 64'(outs()), 64'd0);
`endif

        // Random operands with random acknowledge delay and back-to-back mixes.
        issue(rand_val(), rand_val());
        for (int k = 0; k < 24; k++) begin
            wait_done();
            if (k < 23 && $urandom_range(0, 3) == 0) begin
                ack_b2b(rand_val(), rand_val());
            end else begin
                ack_op(int'($urandom_range(0, 3)));
                if (k < 23) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    issue(rand_val(), rand_val());
                end
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
